fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter width, default 32, instruction word width.
REQ-002 SHALL have parameter depth, default 80, number of instruction words in inst_mem.
REQ-003 SHALL have parameter adr_in, default 64, address/PC width.
REQ-004 SHALL have parameter inc, default 4, byte increment per instruction.
REQ-005 SHALL have port clk  input  1  single system clock; all state changes on rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port start  input  1  level; leaves IDLE and begins fetching at PC 0.
REQ-008 SHALL have port stall  input  1  downstream not ready; hold PC and outputs.
REQ-009 SHALL have port branch_taken  input  1  redirect request, one-cycle pulse.
REQ-010 SHALL have port branch_target  input  adr_in  redirect byte address.
REQ-011 SHALL have port read_adr  output  adr_in  address to inst_mem; equals current PC, combinational.
REQ-012 SHALL have port instruction  input  width  inst_mem read data, valid in the same cycle as read_adr.
REQ-013 SHALL have port inst_out  output  width  registered fetched instruction.
REQ-014 SHALL have port pc_out  output  adr_in  registered PC of inst_out.
REQ-015 SHALL have port inst_valid  output  1  inst_out/pc_out hold a real instruction.
REQ-016 SHALL have port halted  output  1  controller in HALT.
REQ-017 SHALL have port fault  output  1  HALT entered due to misaligned redirect.

Function
REQ-018 SHALL implement FSM states IDLE, FETCH, STALL, HALT.
REQ-019 IDLE: pc held at 0, inst_valid=0; start=1 -> FETCH next edge.
REQ-020 FETCH, stall=0, no branch: inst_out<=instruction, pc_out<=pc, inst_valid<=1, pc<=pc+inc (adr_in-bit wrap).
REQ-021 FETCH, stall=1: pc, inst_out, pc_out, inst_valid unchanged; -> STALL.
REQ-022 STALL: outputs and pc held while stall=1; stall=0 -> FETCH, no instruction skipped or duplicated.
REQ-023 branch_taken=1 in FETCH or STALL SHALL take priority over stall: pc<=branch_target, inst_valid<=0 (one bubble), -> FETCH.
REQ-024 branch_target not a multiple of inc SHALL go to HALT with fault=1; pc unchanged.
REQ-025 Fetched instruction == 32'h00000073 (ecall) in FETCH without stall/branch SHALL be emitted with inst_valid=1, then -> HALT next edge.
REQ-026 pc >= depth*inc at a FETCH edge (sequential or after redirect) SHALL -> HALT, inst_valid<=0, fault=0; out-of-range memory data never emitted.
REQ-027 HALT: pc, inst_out, pc_out held; inst_valid=0, halted=1; exit only by reset.
REQ-028 start, stall and branch_taken SHALL be ignored in IDLE except start; in HALT all ignored.
REQ-029 read_adr SHALL equal pc in every state.

Reset
REQ-030 rst=0 SHALL immediately, without clk, force state=IDLE, pc=0, inst_out=0, pc_out=0, inst_valid=0, halted=0, fault=0.
REQ-031 rst asserted mid-FETCH or mid-STALL SHALL discard in-flight state; after release, block waits for start.
REQ-032 First active edge after rst deassertion SHALL observe the inputs normally; no extra wait states.

Verification
REQ-033 Sequential: mem[k]=k for k=0..9, start=1 -> inst_out=0..9 on consecutive cycles, pc_out=0,4,..,36, inst_valid=1 continuously.
REQ-034 Stall: stall=1 for 3 cycles after word 2 -> inst_out=2, pc_out=8 held 3 cycles, then 3, no gap or repeat.
REQ-035 Branch: branch_taken=1, branch_target=40 while stall=1 -> one cycle inst_valid=0, then inst_out=mem[10], pc_out=40.
REQ-036 Faults/end: branch_target=42 -> halted=1, fault=1; fall-through to pc=320 (depth=80) -> halted=1, fault=0, last emitted pc_out=316.
REQ-037 ecall at word 5 -> pc_out=20 emitted with inst_valid=1, then halted=1, inst_valid=0.
REQ-038 Async reset: rst=0 between clock edges mid-FETCH -> all outputs 0 and state IDLE before next edge; start -> fetch restarts at pc 0.

Source files
------------

// File: rtl/fetch_ctrl_if.sv
// Bundle of fetch controller signals: the control inputs, the instruction
// memory read port and the fetched-instruction output port.
interface fetch_ctrl_if #(
  parameter int width  = 32,
  parameter int adr_in = 64
);
  logic              start;
  logic              stall;
  logic              branch_taken;
  logic [adr_in-1:0] branch_target;
  logic [adr_in-1:0] read_adr;
  logic [width-1:0]  instruction;
  logic [width-1:0]  inst_out;
  logic [adr_in-1:0] pc_out;
  logic              inst_valid;
  logic              halted;
  logic              fault;

  // Handshake: inst_out/pc_out carry a real instruction only while
  // inst_valid=1. The consumer back-pressures with stall (level); while it is
  // high the controller holds pc, inst_out, pc_out and inst_valid unchanged,
  // so one word may stay visible for several cycles. branch_taken is a
  // one-cycle pulse that is accepted even while stall=1. instruction must be
  // the memory word at read_adr in the same cycle.
  modport master (
    input  start, stall, branch_taken, branch_target, instruction,
    output read_adr, inst_out, pc_out, inst_valid, halted, fault
  );

  modport slave (
    output start, stall, branch_taken, branch_target, instruction,
    input  read_adr, inst_out, pc_out, inst_valid, halted, fault
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: walks the PC through inst_mem, honours
// back-pressure and redirects, and halts on ecall, end of memory or a bad target.
module fetch_ctrl #(
  parameter int width  = 32,
  parameter int depth  = 80,
  parameter int adr_in = 64,
  parameter int inc    = 4
) (
  input  logic           clk,
  input  logic           rst,
  fetch_ctrl_if.master   bus,
  output logic [1:0]     state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    STALL = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam logic [adr_in-1:0] pc_limit = adr_in'(depth * inc);
  localparam logic [adr_in-1:0] pc_step  = adr_in'(inc);
  localparam logic [width-1:0]  ecall    = width'(32'h00000073);

  state_t            state, state_nxt;
  logic [adr_in-1:0] pc, pc_nxt;
  logic [adr_in-1:0] pc_out_q, pc_out_nxt;
  logic [width-1:0]  inst_q, inst_nxt;
  logic              valid_q, valid_nxt;
  logic              fault_q, fault_nxt;
  logic              ecall_pend, ecall_pend_nxt;
  logic              target_misaligned;

  assign target_misaligned = (bus.branch_target % pc_step) != '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      pc         <= '0;
      pc_out_q   <= '0;
      inst_q     <= '0;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
      ecall_pend <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      pc_out_q   <= pc_out_nxt;
      inst_q     <= inst_nxt;
      valid_q    <= valid_nxt;
      fault_q    <= fault_nxt;
      ecall_pend <= ecall_pend_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    pc_out_nxt     = pc_out_q;
    inst_nxt       = inst_q;
    valid_nxt      = valid_q;
    fault_nxt      = fault_q;
    ecall_pend_nxt = 1'b0;

    case (state)
      IDLE: begin
        pc_nxt    = '0;
        valid_nxt = 1'b0;
        if (bus.start) state_nxt = FETCH;
      end

      // STALL with stall released fetches immediately, so the word held
      // in pc is emitted exactly once with no extra bubble.
      FETCH, STALL: begin
        if (state == FETCH && ecall_pend) begin
          state_nxt = HALT;
          valid_nxt = 1'b0;
        end else if (bus.branch_taken) begin
          valid_nxt = 1'b0;
          if (target_misaligned) begin
            state_nxt = HALT;
            fault_nxt = 1'b1;
          end else begin
            pc_nxt    = bus.branch_target;
            state_nxt = FETCH;
          end
        end else if (bus.stall) begin
          state_nxt = STALL;
        end else if (pc >= pc_limit) begin
          state_nxt = HALT;
          valid_nxt = 1'b0;
        end else begin
          inst_nxt       = bus.instruction;
          pc_out_nxt     = pc;
          valid_nxt      = 1'b1;
          pc_nxt         = pc + pc_step;
          state_nxt      = FETCH;
          ecall_pend_nxt = (bus.instruction == ecall);
        end
      end

      HALT: begin
        valid_nxt = 1'b0;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.read_adr   = pc;
  assign bus.inst_out   = inst_q;
  assign bus.pc_out     = pc_out_q;
  assign bus.inst_valid = valid_q;
  assign bus.halted     = (state == HALT);
  assign bus.fault      = fault_q;
  assign state_dbg      = state;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: sequential fetch to end of memory, stall,
// redirect, misaligned target, ecall and asynchronous reset.
module tb_fetch_ctrl;

  localparam int width  = 32;
  localparam int adr_in = 64;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_STALL = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  logic        clk;
  logic        rst;
  logic [1:0]  state_dbg;
  logic [63:0] ecall_idx;
  logic [63:0] mem_idx;
  int          checks;
  int          errors;

  fetch_ctrl_if #(.width(width), .adr_in(adr_in)) bus ();

  fetch_ctrl #(.width(width), .depth(80), .adr_in(adr_in), .inc(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.master),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // inst_mem model: mem[k] = k, optionally an ecall at ecall_idx
  always_comb begin
    mem_idx = bus.read_adr >> 2;
    if (bus.read_adr < 64'd320 && bus.read_adr[1:0] == 2'b00)
      bus.instruction = (mem_idx == ecall_idx) ? 32'h00000073 : mem_idx[31:0];
    else
      bus.instruction = 32'hDEADBEEF;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.start         = 1'b0;
    bus.stall         = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    ecall_idx = '1;
    rst       = 1'b0;
    bus.start         = 1'b0;
    bus.stall         = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = '0;
    #12;
    check("rst_inst_out",   64'(bus.inst_out), 64'd0);
    check("rst_pc_out",     bus.pc_out, 64'd0);
    check("rst_valid",      64'(bus.inst_valid), 64'd0);
    check("rst_halted",     64'(bus.halted), 64'd0);
    check("rst_fault",      64'(bus.fault), 64'd0);
    check("rst_read_adr",   bus.read_adr, 64'd0);
    check("rst_state",      64'(state_dbg), 64'(S_IDLE));

    // sequential fetch through all of memory
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("idle_state", 64'(state_dbg), 64'(S_IDLE));
    check("idle_valid", 64'(bus.inst_valid), 64'd0);
    bus.start = 1'b1;
    tick();
    check("start_state", 64'(state_dbg), 64'(S_FETCH));
    check("start_valid", 64'(bus.inst_valid), 64'd0);
    for (int k = 0; k < 10; k++) begin
      tick();
      check("seq_inst",  64'(bus.inst_out), 64'(k));
      check("seq_pc",    bus.pc_out, 64'(4 * k));
      check("seq_valid", 64'(bus.inst_valid), 64'd1);
    end
    for (int k = 10; k < 80; k++) tick();
    check("end_last_inst", 64'(bus.inst_out), 64'd79);
    check("end_last_pc",   bus.pc_out, 64'd316);
    check("end_last_valid", 64'(bus.inst_valid), 64'd1);
    tick();
    check("end_halted", 64'(bus.halted), 64'd1);
    check("end_fault",  64'(bus.fault), 64'd0);
    check("end_valid",  64'(bus.inst_valid), 64'd0);
    check("end_pc_out", bus.pc_out, 64'd316);
    check("end_read_adr", bus.read_adr, 64'd320);
    bus.branch_taken  = 1'b1;
    bus.branch_target = 64'd8;
    tick();
    bus.branch_taken = 1'b0;
    check("halt_ignore_state", 64'(state_dbg), 64'(S_HALT));
    check("halt_ignore_adr",   bus.read_adr, 64'd320);

    // stall, redirect under stall, misaligned redirect from STALL
    do_reset();
    bus.start = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) tick();
    check("stl_pre_inst", 64'(bus.inst_out), 64'd2);
    bus.stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stl_hold_inst",  64'(bus.inst_out), 64'd2);
      check("stl_hold_pc",    bus.pc_out, 64'd8);
      check("stl_hold_valid", 64'(bus.inst_valid), 64'd1);
      check("stl_state",      64'(state_dbg), 64'(S_STALL));
    end
    bus.stall = 1'b0;
    tick();
    check("stl_resume_inst", 64'(bus.inst_out), 64'd3);
    check("stl_resume_pc",   bus.pc_out, 64'd12);
    tick();
    check("stl_next_inst", 64'(bus.inst_out), 64'd4);
    bus.stall         = 1'b1;
    bus.branch_taken  = 1'b1;
    bus.branch_target = 64'd40;
    tick();
    check("br_bubble_valid", 64'(bus.inst_valid), 64'd0);
    check("br_read_adr",     bus.read_adr, 64'd40);
    check("br_state",        64'(state_dbg), 64'(S_FETCH));
    bus.stall        = 1'b0;
    bus.branch_taken = 1'b0;
    tick();
    check("br_inst",  64'(bus.inst_out), 64'd10);
    check("br_pc",    bus.pc_out, 64'd40);
    check("br_valid", 64'(bus.inst_valid), 64'd1);
    bus.stall = 1'b1;
    tick();
    check("br2_state", 64'(state_dbg), 64'(S_STALL));
    bus.branch_taken  = 1'b1;
    bus.branch_target = 64'd42;
    tick();
    bus.branch_taken = 1'b0;
    bus.stall        = 1'b0;
    check("mis_halted",   64'(bus.halted), 64'd1);
    check("mis_fault",    64'(bus.fault), 64'd1);
    check("mis_valid",    64'(bus.inst_valid), 64'd0);
    check("mis_read_adr", bus.read_adr, 64'd44);
    check("mis_pc_out",   bus.pc_out, 64'd40);

    // ecall at word 5
    ecall_idx = 64'd5;
    do_reset();
    check("ecl_rst_fault", 64'(bus.fault), 64'd0);
    bus.start = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) tick();
    check("ecl_pre_inst", 64'(bus.inst_out), 64'd4);
    tick();
    check("ecl_inst",   64'(bus.inst_out), 64'h73);
    check("ecl_pc",     bus.pc_out, 64'd20);
    check("ecl_valid",  64'(bus.inst_valid), 64'd1);
    check("ecl_halted0", 64'(bus.halted), 64'd0);
    tick();
    check("ecl_halted", 64'(bus.halted), 64'd1);
    check("ecl_valid0", 64'(bus.inst_valid), 64'd0);
    check("ecl_pc_hold", bus.pc_out, 64'd20);
    check("ecl_fault",  64'(bus.fault), 64'd0);
    ecall_idx = '1;

    // asynchronous reset mid-FETCH
    do_reset();
    bus.start = 1'b1;
    tick();
    tick();
    tick();
    check("ar_pre_inst", 64'(bus.inst_out), 64'd1);
    #3;
    rst       = 1'b0;
    bus.start = 1'b0;
    #1;
    check("ar_inst_out", 64'(bus.inst_out), 64'd0);
    check("ar_pc_out",   bus.pc_out, 64'd0);
    check("ar_valid",    64'(bus.inst_valid), 64'd0);
    check("ar_read_adr", bus.read_adr, 64'd0);
    check("ar_state",    64'(state_dbg), 64'(S_IDLE));
    #1;
    rst = 1'b1;
    tick();
    check("ar_wait_state", 64'(state_dbg), 64'(S_IDLE));
    bus.start = 1'b1;
    tick();
    check("ar_fetch_state", 64'(state_dbg), 64'(S_FETCH));
    tick();
    check("ar_restart_inst",  64'(bus.inst_out), 64'd0);
    check("ar_restart_pc",    bus.pc_out, 64'd0);
    check("ar_restart_valid", 64'(bus.inst_valid), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
